// File: rtl/led_seq_ctrl.sv
// led_seq_ctrl: request-driven LED pattern sequencer stepped by a TICK_DIV prescaler.
// Defining LED_SEQ_FAULT_EN adds the FAULT port and its 1111/0000 override.
module led_seq_ctrl #(
  parameter logic [31:0] TICK_DIV = 32'h01312D00
) (
  input  logic       FAB_CLK,
  input  logic       FAB_RST,
  input  logic       REQ,
  input  logic [1:0] PAT_SEL,
`ifdef LED_SEQ_FAULT_EN
  input  logic       FAULT,
`endif
  output logic       ACK,
  output logic       BUSY,
  output logic [3:0] LED
);

  typedef enum logic {ST_IDLE = 1'b0, ST_RUN = 1'b1} state_t;

  state_t      state_r, state_nx_s;
  logic [1:0]  pat_r, pat_nx_s;
  logic [1:0]  step_r, step_nx_s;
  logic [31:0] cnt_r, cnt_nx_s;
  logic        armed_r, armed_nx_s;
  logic        ack_r, busy_r;
  logic [3:0]  led_r, led_nx_s;
  logic        tick_s, accept_s, fault_fall_s;

  // LED value for a given pattern code and step index
  function automatic logic [3:0] pat_led(input logic [1:0] pat, input logic [1:0] step);
    logic [3:0] led;
    case (pat)
      2'd1:    led = step[0] ? 4'b0110 : 4'b1001;
      2'd2:    led = 4'b0001 << step;
      2'd3:    led = step[0] ? 4'b0000 : 4'b1111;
      default: led = 4'b0000;
    endcase
    return led;
  endfunction

  // Index of the last step before wrapping back to step 0
  function automatic logic [1:0] last_step(input logic [1:0] pat);
    logic [1:0] last;
    case (pat)
      2'd1:    last = 2'd1;
      2'd2:    last = 2'd3;
      2'd3:    last = 2'd1;
      default: last = 2'd0;
    endcase
    return last;
  endfunction

`ifdef LED_SEQ_FAULT_EN
  logic fault_r;
  assign fault_fall_s = fault_r & ~FAULT;

  // Previous FAULT sample, used to find the first fault cycle and the falling edge
  always_ff @(posedge FAB_CLK or posedge FAB_RST) begin
    if (FAB_RST) begin
      fault_r <= 1'b0;
    end else begin
      fault_r <= FAULT;
    end
  end
`else
  assign fault_fall_s = 1'b0;
`endif

  // Next-state, prescaler, step and LED computation
  always_comb begin
    tick_s     = (cnt_r == (TICK_DIV - 32'd1));
    accept_s   = REQ & armed_r;
    state_nx_s = state_r;
    pat_nx_s   = pat_r;
    step_nx_s  = step_r;
    led_nx_s   = 4'b0000;
    armed_nx_s = accept_s ? 1'b0 : (armed_r | ~REQ);
    cnt_nx_s   = (accept_s | fault_fall_s | tick_s) ? 32'd0 : (cnt_r + 32'd1);

    if (accept_s) begin
      pat_nx_s   = PAT_SEL;
      state_nx_s = (PAT_SEL == 2'd0) ? ST_IDLE : ST_RUN;
    end else begin
      pat_nx_s   = pat_r;
      state_nx_s = state_r;
    end

    // An accept outranks a coincident tick, so the new pattern starts at step 0
    if (accept_s || fault_fall_s) begin
      step_nx_s = 2'd0;
    end else if (tick_s && (state_r == ST_RUN)) begin
      step_nx_s = (step_r == last_step(pat_r)) ? 2'd0 : (step_r + 2'd1);
    end else begin
      step_nx_s = step_r;
    end

    case (state_nx_s)
      ST_RUN:  led_nx_s = pat_led(pat_nx_s, step_nx_s);
      ST_IDLE: led_nx_s = 4'b0000;
      default: led_nx_s = 4'b0000;
    endcase

`ifdef LED_SEQ_FAULT_EN
    if (FAULT) begin
      if (!fault_r) begin
        led_nx_s = 4'b1111;
      end else if (tick_s) begin
        led_nx_s = ~led_r;
      end else begin
        led_nx_s = led_r;
      end
    end else begin
      led_nx_s = led_nx_s;
    end
`endif
  end

  // State, prescaler and registered outputs
  always_ff @(posedge FAB_CLK or posedge FAB_RST) begin
    if (FAB_RST) begin
      state_r <= ST_IDLE;
      pat_r   <= 2'd0;
      step_r  <= 2'd0;
      cnt_r   <= 32'd0;
      armed_r <= 1'b1;
      ack_r   <= 1'b0;
      busy_r  <= 1'b0;
      led_r   <= 4'b0000;
    end else begin
      state_r <= state_nx_s;
      pat_r   <= pat_nx_s;
      step_r  <= step_nx_s;
      cnt_r   <= cnt_nx_s;
      armed_r <= armed_nx_s;
      ack_r   <= accept_s;
      busy_r  <= (state_nx_s == ST_RUN);
      led_r   <= led_nx_s;
    end
  end

  assign ACK  = ack_r;
  assign BUSY = busy_r;
  assign LED  = led_r;

endmodule

// File: tb/tb_led_seq_ctrl.sv
// Bench for led_seq_ctrl (TICK_DIV=4): directed vector table, corner sequences,
// and random stimulus against a cycles-since-restart reference model.
module tb_led_seq_ctrl;

  localparam int TD = 4;

  logic       FAB_CLK;
  logic       FAB_RST;
  logic       REQ;
  logic [1:0] PAT_SEL;
`ifdef LED_SEQ_FAULT_EN
  logic       FAULT;
`endif
  logic       ACK;
  logic       BUSY;
  logic [3:0] LED;

  int checks = 0;
  int errors = 0;

  led_seq_ctrl #(.TICK_DIV(32'd4)) dut (
    .FAB_CLK (FAB_CLK),
    .FAB_RST (FAB_RST),
    .REQ     (REQ),
    .PAT_SEL (PAT_SEL),
`ifdef LED_SEQ_FAULT_EN
    .FAULT   (FAULT),
`endif
    .ACK     (ACK),
    .BUSY    (BUSY),
    .LED     (LED)
  );

  initial FAB_CLK = 1'b0;
  always #5 FAB_CLK = ~FAB_CLK;

  // Reference model: pattern tables and elapsed cycles since the last restart
  logic [3:0] seq_tbl [4][4] = '{'{4'h0, 4'h0, 4'h0, 4'h0},
                                 '{4'b1001, 4'b0110, 4'h0, 4'h0},
                                 '{4'b0001, 4'b0010, 4'b0100, 4'b1000},
                                 '{4'b1111, 4'b0000, 4'h0, 4'h0}};
  int         seq_len [4] = '{1, 2, 4, 2};
  logic [1:0] m_pat;
  int         m_elapsed;
  bit         m_armed, m_ack, m_fprev;
  logic [3:0] m_led, m_fled;

  typedef struct packed {
    logic       req;
    logic [1:0] sel;
    logic       ack;
    logic       busy;
    logic [3:0] led;
  } vec_t;
  vec_t vq[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pat = 2'd0; m_elapsed = 0; m_armed = 1'b1; m_ack = 1'b0;
    m_fprev = 1'b0; m_led = 4'h0; m_fled = 4'h0;
  endtask

  task automatic model_step();
    bit tick, acc;
    tick = ((m_elapsed % TD) == TD - 1);
    acc = REQ && m_armed;
    m_ack = acc;
    if (acc) begin
      m_pat = PAT_SEL; m_elapsed = 0; m_armed = 1'b0;
    end else begin
      m_elapsed++;
      if (!REQ) m_armed = 1'b1;
    end
`ifdef LED_SEQ_FAULT_EN
    if (FAULT) begin
      if (!m_fprev) m_fled = 4'hF;
      else if (tick) m_fled = ~m_fled;
    end else if (m_fprev) begin
      m_elapsed = 0;
    end
    m_fprev = FAULT;
`endif
    m_led = (m_pat != 2'd0) ? seq_tbl[m_pat][(m_elapsed / TD) % seq_len[m_pat]] : 4'h0;
`ifdef LED_SEQ_FAULT_EN
    if (FAULT) m_led = m_fled;
`endif
  endtask

  task automatic cycle();
    model_step();
    @(posedge FAB_CLK);
    #1;
    chk("model_ack", {31'd0, ACK}, {31'd0, m_ack});
    chk("model_busy", {31'd0, BUSY}, {31'd0, (m_pat != 2'd0)});
    chk("model_led", {28'd0, LED}, {28'd0, m_led});
  endtask

  task automatic add(input int n, input logic req, input logic [1:0] sel,
                     input logic ack, input logic busy, input logic [3:0] led);
    for (int i = 0; i < n; i++) vq.push_back('{req, sel, ack, busy, led});
  endtask

  initial begin
    FAB_RST = 1'b1; REQ = 1'b0; PAT_SEL = 2'd0;
`ifdef LED_SEQ_FAULT_EN
    FAULT = 1'b0;
`endif
    model_reset();
    repeat (2) @(posedge FAB_CLK);
    #1;
    chk("reset_led", {28'd0, LED}, 32'd0);
    chk("reset_ack", {31'd0, ACK}, 32'd0);
    chk("reset_busy", {31'd0, BUSY}, 32'd0);
    FAB_RST = 1'b0;

    // Idle for 20 cycles: nothing may move
    for (int i = 0; i < 20; i++) begin
      cycle();
      chk("idle_led", {28'd0, LED}, 32'd0);
      chk("idle_ack", {31'd0, ACK}, 32'd0);
    end

    // Pattern 2, accept on a tick with pattern 3, held REQ with pattern 1, then off
    add(1, 1'b1, 2'd2, 1'b1, 1'b1, 4'b0001);
    add(3, 1'b0, 2'd0, 1'b0, 1'b1, 4'b0001);
    add(4, 1'b0, 2'd0, 1'b0, 1'b1, 4'b0010);
    add(4, 1'b0, 2'd0, 1'b0, 1'b1, 4'b0100);
    add(4, 1'b0, 2'd0, 1'b0, 1'b1, 4'b1000);
    add(4, 1'b0, 2'd0, 1'b0, 1'b1, 4'b0001);
    add(1, 1'b1, 2'd3, 1'b1, 1'b1, 4'b1111);
    add(3, 1'b0, 2'd0, 1'b0, 1'b1, 4'b1111);
    add(1, 1'b0, 2'd0, 1'b0, 1'b1, 4'b0000);
    add(1, 1'b1, 2'd1, 1'b1, 1'b1, 4'b1001);
    add(3, 1'b1, 2'd3, 1'b0, 1'b1, 4'b1001);
    add(4, 1'b1, 2'd2, 1'b0, 1'b1, 4'b0110);
    add(2, 1'b1, 2'd1, 1'b0, 1'b1, 4'b1001);
    add(2, 1'b0, 2'd0, 1'b0, 1'b1, 4'b1001);
    add(1, 1'b0, 2'd0, 1'b0, 1'b1, 4'b0110);
    add(1, 1'b1, 2'd0, 1'b1, 1'b0, 4'b0000);
    add(1, 1'b1, 2'd2, 1'b0, 1'b0, 4'b0000);
    add(1, 1'b0, 2'd0, 1'b0, 1'b0, 4'b0000);
    for (int i = 0; i < vq.size(); i++) begin
      REQ = vq[i].req; PAT_SEL = vq[i].sel;
      cycle();
      chk($sformatf("vec%0d_ack", i), {31'd0, ACK}, {31'd0, vq[i].ack});
      chk($sformatf("vec%0d_busy", i), {31'd0, BUSY}, {31'd0, vq[i].busy});
      chk($sformatf("vec%0d_led", i), {28'd0, LED}, {28'd0, vq[i].led});
    end

    // Asynchronous reset mid-RUN with REQ high through release
    REQ = 1'b1; PAT_SEL = 2'd2; cycle();
    REQ = 1'b0;
    repeat (6) cycle();
    chk("pre_rst_led", {28'd0, LED}, 32'b0010);
    #2 FAB_RST = 1'b1; REQ = 1'b1; PAT_SEL = 2'd0;
    #1;
    chk("async_rst_led", {28'd0, LED}, 32'd0);
    chk("async_rst_busy", {31'd0, BUSY}, 32'd0);
    @(posedge FAB_CLK); #1;
    chk("in_rst_ack", {31'd0, ACK}, 32'd0);
    #2 FAB_RST = 1'b0;
    model_reset();
    cycle();
    chk("post_rst_ack", {31'd0, ACK}, 32'd1);
    chk("post_rst_busy", {31'd0, BUSY}, 32'd0);
    REQ = 1'b0; cycle();
    chk("post_rst_idle", {31'd0, BUSY}, 32'd0);

`ifdef LED_SEQ_FAULT_EN
    // Fault override over pattern 2, then release back to step 0
    REQ = 1'b1; PAT_SEL = 2'd2; cycle();
    REQ = 1'b0;
    repeat (5) cycle();
    FAULT = 1'b1; cycle();
    chk("fault_first", {28'd0, LED}, 32'b1111);
    repeat (11) cycle();
    FAULT = 1'b0; cycle();
    chk("fault_release", {28'd0, LED}, 32'b0001);
`endif

    // Random requests against the model
    for (int i = 0; i < 3000; i++) begin
      REQ = ($urandom_range(0, 3) == 0);
      PAT_SEL = 2'($urandom_range(0, 3));
`ifdef LED_SEQ_FAULT_EN
      if ($urandom_range(0, 15) == 0) FAULT = ~FAULT;
`endif
      cycle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/led_seq_ctrl.md
LED_SEQ_CTRL -- requirements
Module: led_seq_ctrl

Interface
REQ-001 Parameter: TICK_DIV, default 32'h01312D00, FAB_CLK cycles per pattern step; legal range 2..2^32-1.
REQ-002 FAB_CLK  input  1  fabric clock; all state changes on its rising edge.
REQ-003 FAB_RST  input  1  reset, asynchronous, active-high.
REQ-004 REQ  input  1  pattern-change request, level; sampled every FAB_CLK edge.
REQ-005 PAT_SEL  input  2  requested pattern code, valid while REQ high.
REQ-006 ACK  output  1  one-cycle acceptance pulse for REQ.
REQ-007 BUSY  output  1  high while a non-off pattern is running.
REQ-008 LED  output  4  registered LED drive, LED[0] = LED1 ... LED[3] = LED4.
REQ-009 FAULT  input  1  fault override, present only with LED_SEQ_FAULT_EN (REQ-030).

Function
REQ-010 Prescaler: 32-bit count 0..TICK_DIV-1, wraps to 0; tick = single-cycle pulse when count == TICK_DIV-1.
REQ-011 States: IDLE (LED=0000, BUSY=0), RUN (LED steps through the pattern, BUSY=1).
REQ-012 Patterns: 0 = off; 1 = 1001,0110 (length 2); 2 = 0001,0010,0100,1000 (length 4); 3 = 1111,0000 (length 2).
REQ-013 Step index is 2 bits; advances on tick in RUN; wraps to 0 after the last step of the active pattern's length.
REQ-014 Accept: REQ high and armed -> latch PAT_SEL, ACK=1 next cycle, prescaler and step index cleared in the same cycle.
REQ-015 Accepted PAT_SEL 1..3 -> RUN; LED shows step-0 value in the same cycle ACK is high.
REQ-016 Accepted PAT_SEL 0 -> IDLE; LED=0000 and BUSY=0 in the ACK cycle.
REQ-017 Arming: block disarms on accept and rearms only after REQ sampled low; REQ held high yields exactly one ACK.
REQ-018 Accept and tick in the same cycle: accept wins; no step advance; prescaler restarts at 0.
REQ-019 Accept while in RUN: pattern switches immediately, no drain of the old pattern.
REQ-020 Prescaler runs in IDLE; tick has no effect in IDLE.
REQ-021 PAT_SEL changes while REQ low or after accept are ignored.

Reset
REQ-022 FAB_RST high: state IDLE, prescaler 0, step 0, latched pattern 0, armed, immediately and independent of FAB_CLK.
REQ-023 Outputs during and after reset: LED=0000, ACK=0, BUSY=0.
REQ-024 Reset mid-request: no ACK for that request; REQ still high at release is accepted on the first edge after release.
REQ-025 Reset release is synchronised by the integrating design; the block does not re-synchronise it.

Configuration
REQ-030 Macro LED_SEQ_FAULT_EN defined: FAULT port exists; FAULT high forces LED to alternate 1111/0000 on each tick, starting with 1111 on the first cycle FAULT is sampled high.
REQ-031 During FAULT, requests are still accepted, acknowledged and latched per REQ-014..REQ-019, but LED shows only the fault pattern; BUSY follows state.
REQ-032 FAULT falling: prescaler and step cleared; LED shows step 0 of the latched pattern on the next cycle.
REQ-033 Macro undefined: no FAULT port, no override logic; behaviour is REQ-010..REQ-025 only.

Verification (TICK_DIV=4 in bench)
REQ-040 Reset, then idle 20 cycles -> LED=0000, BUSY=0, ACK never high.
REQ-041 REQ=1, PAT_SEL=2 for 1 cycle -> ACK one cycle later, LED=0001, then 0010,0100,1000,0001 every 4 cycles, BUSY=1.
REQ-042 REQ held high 10 cycles with PAT_SEL=1 -> exactly one ACK; LED 1001/0110 alternating every 4 cycles.
REQ-043 Request PAT_SEL=3 on the cycle the tick fires during pattern 2 -> LED=1111 in the ACK cycle, next change 4 cycles later to 0000.
REQ-044 FAB_RST pulsed mid-RUN, asynchronous to FAB_CLK -> LED=0000, BUSY=0 immediately; request with PAT_SEL=0 afterwards -> ACK, stays IDLE.
REQ-045 With LED_SEQ_FAULT_EN: pattern 2 running, FAULT=1 for 12 cycles -> LED 1111/0000 toggling every 4 cycles; FAULT=0 -> LED=0001 next cycle.
